// File: rtl/fractcam_upd_pkg.sv
// ---------------------------------------------------------------------------
// fractcam_upd_pkg
// Shared definitions for the fractional-TCAM rule-update path:
//   - upd_state_e : update scheduler state encoding
//   - UPD_CYCLES_DEF : default number of write beats per rule update
//   - STATS_W : width of the optional completed-update counter
//   - idx_w() : index width helper that never returns zero
// ---------------------------------------------------------------------------
package fractcam_upd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } upd_state_e;

  localparam int UPD_CYCLES_DEF = 32;
  localparam int STATS_W        = 16;

  // Width needed to index n items, at least one bit so single-entry
  // configurations still get a legal vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Starting at ptr and walking upward
// modulo RN, the first asserted request wins. The pointer register lives in
// the parent so this block stays purely combinational.
// Ports:
//   req    in  RN   request vector
//   ptr    in  IDW  highest-priority index for this decision
//   en     in  1    arbitration enable; gnt is all-zero when low
//   gnt    out RN   one-hot grant (all-zero when nothing is requested)
//   gnt_id out IDW  encoded index of the granted request
// ---------------------------------------------------------------------------
module rr_arbiter
  import fractcam_upd_pkg::*;
#(
  parameter int RN  = 2,
  parameter int IDW = idx_w(RN)
) (
  input  logic [RN-1:0]  req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [RN-1:0]  gnt,
  output logic [IDW-1:0] gnt_id
);

  always_comb begin
    int   idx;
    logic found;
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    if (en) begin
      for (int i = 0; i < RN; i++) begin
        idx = (int'(ptr) + i) % RN;
        if (!found && req[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          gnt_id   = IDW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/update_sched.sv
// ---------------------------------------------------------------------------
// update_sched
// Rule-update scheduler for the fractional TCAM. Round-robin arbitrates
// rule-insert requests, then drives the update datapath with one clear cycle
// followed by UPD_CYCLES write cycles while key and slice select are held.
// busy stalls the search side for the whole update; done pulses once with
// the served requester id.
//
// Optional build macro: UPDATE_SCHED_STATS_EN adds the 16-bit saturating
// upd_count output counting completed (non-aborted) updates.
//
// Ports:
//   wclk       in   1      clock, rising edge
//   reset      in   1      synchronous, active-high; aborts any update
//   req_valid  in   RN     per-requester request
//   req_ready  out  RN     one-hot combinational grant, only in IDLE
//   req_key    in   RN*W   key of requester r at [r*W +: W]
//   req_slice  in   RN*SN  slice of requester r at [r*SN +: SN]
//   sk         out  W      registered key to the datapath
//   we_sel     out  SN     registered slice select to the datapath
//   wr         out  1      datapath write strobe
//   upd_reset  out  1      datapath clear
//   busy       out  1      update in progress
//   done       out  1      one-cycle completion pulse
//   upd_count  out  16     completed updates (UPDATE_SCHED_STATS_EN only)
//   done_id    out  IDW    requester served by the completing update
// ---------------------------------------------------------------------------
module update_sched
  import fractcam_upd_pkg::*;
#(
  parameter int W          = 40,
  parameter int SN         = 2,
  parameter int RN         = 2,
  parameter int UPD_CYCLES = UPD_CYCLES_DEF,
  parameter int IDW        = idx_w(RN),
  parameter int CW         = idx_w(UPD_CYCLES)
) (
  input  logic               wclk,
  input  logic               reset,
  input  logic [RN-1:0]      req_valid,
  output logic [RN-1:0]      req_ready,
  input  logic [RN*W-1:0]    req_key,
  input  logic [RN*SN-1:0]   req_slice,
  output logic [W-1:0]       sk,
  output logic [SN-1:0]      we_sel,
  output logic               wr,
  output logic               upd_reset,
  output logic               busy,
  output logic               done,
`ifdef UPDATE_SCHED_STATS_EN
  output logic [STATS_W-1:0] upd_count,
`endif
  output logic [IDW-1:0]     done_id
);

  upd_state_e     state_q, state_d;
  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] id_q;
  logic [CW-1:0]  beat_q;
  logic [W-1:0]   sk_q;
  logic [SN-1:0]  sel_q;

  logic [RN-1:0]  gnt;
  logic [IDW-1:0] gnt_id;
  logic           arb_en;
  logic           accept;
  logic           last_beat;

  // Grants are only offered in IDLE and never while reset is held, so a
  // requester can not be accepted in the same cycle the scheduler is cleared.
  assign arb_en = (state_q == IDLE) && !reset;

  rr_arbiter #(
    .RN  (RN),
    .IDW (IDW)
  ) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr_q),
    .en     (arb_en),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  // gnt is only ever set on a valid request, so any grant is an accept.
  assign accept    = |gnt;
  assign last_beat = (beat_q == CW'(UPD_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CLR;
      CLR:     state_d = WRITE;
      WRITE:   if (last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      beat_q   <= '0;
      sk_q     <= '0;
      sel_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && accept) begin
        sk_q     <= req_key[int'(gnt_id)*W +: W];
        sel_q    <= req_slice[int'(gnt_id)*SN +: SN];
        id_q     <= gnt_id;
        rr_ptr_q <= (int'(gnt_id) == RN - 1) ? '0 : IDW'(int'(gnt_id) + 1);
      end
      if (state_q == CLR) begin
        beat_q <= '0;
      end else if (state_q == WRITE && !last_beat) begin
        beat_q <= beat_q + 1'b1;
      end
    end
  end

  // Strobes are gated by reset so an abort takes effect in the very cycle
  // reset is raised rather than one cycle later.
  assign req_ready = gnt;
  assign sk        = sk_q;
  assign we_sel    = sel_q;
  assign wr        = (state_q == WRITE) && !reset;
  assign done      = (state_q == DONE) && !reset;
  assign busy      = (state_q != IDLE) && !reset;
  assign upd_reset = reset || (state_q == CLR);
  assign done_id   = (RN == 1) ? '0 : id_q;

`ifdef UPDATE_SCHED_STATS_EN
  logic [STATS_W-1:0] upd_count_q;

  // Only DONE advances the count, so aborted updates never contribute.
  always_ff @(posedge wclk) begin
    if (reset) begin
      upd_count_q <= '0;
    end else if (state_q == DONE && upd_count_q != {STATS_W{1'b1}}) begin
      upd_count_q <= upd_count_q + 1'b1;
    end
  end

  assign upd_count = upd_count_q;
`endif

endmodule

// File: tb/tb_update_sched.sv
// ---------------------------------------------------------------------------
// tb_update_sched
// Self-checking bench for update_sched (W=40, SN=2, RN=2, UPD_CYCLES=32).
// Accepted requests are pushed to a scoreboard; a monitor pops them on done
// and checks held key/slice during every write beat.
// ---------------------------------------------------------------------------
module tb_update_sched;

  localparam int W   = 40;
  localparam int SN  = 2;
  localparam int RN  = 2;
  localparam int UPD = 32;

  logic            wclk = 1'b0;
  logic            reset;
  logic [RN-1:0]   req_valid;
  logic [RN-1:0]   req_ready;
  logic [RN*W-1:0] req_key;
  logic [RN*SN-1:0] req_slice;
  logic [W-1:0]    sk;
  logic [SN-1:0]   we_sel;
  logic            wr, upd_reset, busy, done;
  logic [0:0]      done_id;
`ifdef UPDATE_SCHED_STATS_EN
  logic [15:0]     upd_count;
`endif

  update_sched #(
    .W (W), .SN (SN), .RN (RN), .UPD_CYCLES (UPD)
  ) dut (
    .wclk      (wclk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_key   (req_key),
    .req_slice (req_slice),
    .sk        (sk),
    .we_sel    (we_sel),
    .wr        (wr),
    .upd_reset (upd_reset),
    .busy      (busy),
    .done      (done),
`ifdef UPDATE_SCHED_STATS_EN
    .upd_count (upd_count),
`endif
    .done_id   (done_id)
  );

  always #5 wclk = ~wclk;

  typedef struct packed {
    logic [0:0]    id;
    logic [W-1:0]  key;
    logic [SN-1:0] sl;
  } exp_t;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   cyc          = 0;
  int   wr_beats     = 0;
  int   rr_exp       = 0;

  always @(posedge wclk) cyc <= cyc + 1;

  // Scoreboard monitor: sampled late in the low phase, after stimulus settles.
  always @(negedge wclk) begin
    #2;
    if (reset) begin
      sb.delete();
      wr_beats = 0;
    end else begin
      if (wr) begin
        wr_beats++;
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_wr_unexpected: wr=1 at cycle %0d with no accepted request", cyc);
        end else if (sk !== sb[0].key || we_sel !== sb[0].sl) begin
          tests_failed++;
          $display("FAIL sb_wr_data: sk=%h we_sel=%0d, required sk=%h we_sel=%0d",
                   sk, we_sel, sb[0].key, sb[0].sl);
        end
      end
      if (done) begin
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_done_unexpected: done=1 at cycle %0d with empty scoreboard", cyc);
        end else begin
          if (done_id !== sb[0].id || wr_beats != UPD) begin
            tests_failed++;
            $display("FAIL sb_done: done_id=%0d wr_beats=%0d, required done_id=%0d wr_beats=%0d",
                     done_id, wr_beats, sb[0].id, UPD);
          end
          void'(sb.pop_front());
        end
        wr_beats = 0;
      end
    end
  end

  function automatic logic [W-1:0] key_of(input int n);
    return 40'h12_3456_789A ^ (40'(n) * 40'h01_0203_0405);
  endfunction

  function automatic int model_grant(input logic [RN-1:0] v, input int ptr);
    for (int i = 0; i < RN; i++) begin
      if (v[(ptr + i) % RN]) return (ptr + i) % RN;
    end
    return -1;
  endfunction

  task automatic set_req(input int r, input logic v, input logic [W-1:0] k,
                         input logic [SN-1:0] s);
    req_valid[r]            = v;
    req_key[r*W +: W]       = k;
    req_slice[r*SN +: SN]   = s;
  endtask

  // Called at a falling edge with requests driven; returns the granted id and
  // the cycle of the accept, checks the grant against the round-robin model
  // and records the expected update in the scoreboard.
  task automatic wait_accept(input int max_cyc, output int gid, output int acc_cyc);
    int exp_g;
    gid     = -1;
    acc_cyc = -1;
    for (int i = 0; i < max_cyc; i++) begin
      #1;
      if (|req_ready) begin
        exp_g   = model_grant(req_valid, rr_exp);
        gid     = req_ready[1] ? 1 : 0;
        acc_cyc = cyc;
        tests_run++;
        if (req_ready !== (RN'(1) << exp_g)) begin
          tests_failed++;
          $display("FAIL grant: req_ready=%b, required one-hot at %0d", req_ready, exp_g);
        end
        sb.push_back('{id: 1'(gid), key: req_key[gid*W +: W], sl: req_slice[gid*SN +: SN]});
        rr_exp = (gid + 1) % RN;
        return;
      end
      @(negedge wclk);
    end
    tests_run++;
    tests_failed++;
    $display("FAIL accept_timeout: no req_ready within %0d cycles, required a grant", max_cyc);
  endtask

  task automatic wait_idle(input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge wclk);
      #1;
      if (!busy) return;
    end
    tests_run++;
    tests_failed++;
    $display("FAIL idle_timeout: busy still 1 after %0d cycles, required 0", max_cyc);
  endtask

  task automatic pulse_reset();
    @(negedge wclk);
    reset = 1'b1;
    @(negedge wclk);
    @(negedge wclk);
    reset  = 1'b0;
    rr_exp = 0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = '1;
    set_req(0, 1'b1, key_of(1), 2'd1);
    set_req(1, 1'b1, key_of(2), 2'd3);
    @(negedge wclk);
    @(negedge wclk);
    #1;
    tests_run++;
    if ({req_ready, wr, done, busy, upd_reset} !== 6'b00_0001) begin
      tests_failed++;
      $display("FAIL reset_ctrl: ready/wr/done/busy/upd_reset=%b, required 000001",
               {req_ready, wr, done, busy, upd_reset});
    end
    tests_run++;
    if ({sk, we_sel, done_id} !== '0) begin
      tests_failed++;
      $display("FAIL reset_data: sk=%h we_sel=%0d done_id=%0d, required all 0", sk, we_sel, done_id);
    end
    req_valid = '0;
    reset     = 1'b0;
    rr_exp    = 0;
    @(negedge wclk);
    #1;
    tests_run++;
    if ({upd_reset, busy, req_ready} !== 4'b0) begin
      tests_failed++;
      $display("FAIL post_reset_idle: upd_reset/busy/ready=%b, required 0000", {upd_reset, busy, req_ready});
    end
  endtask

  task automatic test_single();
    int gid, t, c0, bad;
    @(negedge wclk);
    set_req(0, 1'b1, 40'h12_3456_789A, 2'd2);
    c0 = cyc;
    wait_accept(5, gid, t);
    tests_run++;
    if (gid != 0 || t != c0) begin
      tests_failed++;
      $display("FAIL single_accept: gid=%0d cycle=%0d, required gid=0 cycle=%0d", gid, t, c0);
    end
    @(negedge wclk);
    req_valid[0] = 1'b0;
    #1;
    tests_run++;
    if ({upd_reset, wr, busy, req_ready} !== 5'b10100 || cyc != t + 1) begin
      tests_failed++;
      $display("FAIL single_clr: upd_reset/wr/busy/ready=%b cycle=%0d, required 10100 at %0d",
               {upd_reset, wr, busy, req_ready}, cyc, t + 1);
    end
    bad = 0;
    for (int i = 0; i < UPD; i++) begin
      @(negedge wclk);
      #1;
      if (wr !== 1'b1 || upd_reset !== 1'b0 || done !== 1'b0 ||
          sk !== 40'h12_3456_789A || we_sel !== 2'd2) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL single_write: %0d bad write beats, required 0 of %0d", bad, UPD);
    end
    @(negedge wclk);
    #1;
    tests_run++;
    if (done !== 1'b1 || done_id !== 1'b0 || wr !== 1'b0 || cyc != t + 34) begin
      tests_failed++;
      $display("FAIL single_done: done=%b done_id=%0d wr=%b cycle=%0d, required 1 0 0 at %0d",
               done, done_id, wr, cyc, t + 34);
    end
    @(negedge wclk);
    #1;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_release: busy=%b done=%b at cycle %0d, required 0 0", busy, done, cyc);
    end
  endtask

  task automatic test_back_to_back();
    int gid, t, prev;
    pulse_reset();
    set_req(0, 1'b1, key_of(10), 2'd1);
    set_req(1, 1'b1, key_of(11), 2'd3);
    prev = -1;
    for (int k = 0; k < 4; k++) begin
      wait_accept(UPD + 10, gid, t);
      tests_run++;
      if (gid != k % 2) begin
        tests_failed++;
        $display("FAIL b2b_order: accept %0d granted %0d, required %0d", k, gid, k % 2);
      end
      if (prev >= 0) begin
        tests_run++;
        if (t - prev != UPD + 3) begin
          tests_failed++;
          $display("FAIL b2b_period: accept spacing %0d, required %0d", t - prev, UPD + 3);
        end
      end
      prev = t;
      @(negedge wclk);
      if (k == 3) req_valid = '0;
    end
    wait_idle(UPD + 10);
  endtask

  task automatic test_late_request();
    int gid, t, d, bad;
    @(negedge wclk);
    set_req(0, 1'b1, key_of(20), 2'd0);
    wait_accept(5, gid, t);
    @(negedge wclk);
    req_valid[0] = 1'b0;
    for (int i = 0; i < 12; i++) @(negedge wclk);
    set_req(1, 1'b1, key_of(21), 2'd2);
    bad = 0;
    d   = -1;
    for (int i = 0; i < UPD + 5; i++) begin
      #1;
      if (req_ready !== 2'b00) bad++;
      if (done === 1'b1) begin
        d = cyc;
        break;
      end
      @(negedge wclk);
    end
    tests_run++;
    if (bad != 0 || d < 0) begin
      tests_failed++;
      $display("FAIL late_hold: %0d cycles with req_ready set, done seen=%0d, required 0 and seen", bad, d >= 0);
    end
    @(negedge wclk);
    wait_accept(1, gid, t);
    tests_run++;
    if (gid != 1 || t != d + 1) begin
      tests_failed++;
      $display("FAIL late_accept: gid=%0d cycle=%0d, required gid=1 cycle=%0d", gid, t, d + 1);
    end
    @(negedge wclk);
    req_valid = '0;
    wait_idle(UPD + 10);
  endtask

  // Accept r0 (pointer moves to 1), abort on write beat 10 and check the
  // pointer returned to 0 by granting r0 with both requesters valid.
  task automatic run_abort();
    int gid, t, bad;
    @(negedge wclk);
    set_req(0, 1'b1, key_of(30), 2'd1);
    wait_accept(5, gid, t);
    @(negedge wclk);
    req_valid[0] = 1'b0;
    for (int i = 0; i < 11; i++) @(negedge wclk);
    #1;
    tests_run++;
    if (wr !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_pre: wr=%b on beat 10, required 1", wr);
    end
    reset  = 1'b1;
    rr_exp = 0;
    @(negedge wclk);
    #1;
    tests_run++;
    if ({wr, busy, done, upd_reset} !== 4'b0001) begin
      tests_failed++;
      $display("FAIL abort_now: wr/busy/done/upd_reset=%b, required 0001", {wr, busy, done, upd_reset});
    end
    reset = 1'b0;
    bad   = 0;
    for (int i = 0; i < UPD + 5; i++) begin
      @(negedge wclk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0 || wr !== 1'b0) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL abort_quiet: %0d cycles with done/busy/wr after abort, required 0", bad);
    end
  endtask

  task automatic test_abort();
    int gid, t;
    run_abort();
    set_req(0, 1'b1, key_of(31), 2'd2);
    set_req(1, 1'b1, key_of(32), 2'd3);
    wait_accept(5, gid, t);
    tests_run++;
    if (gid != 0) begin
      tests_failed++;
      $display("FAIL abort_ptr: granted %0d after abort, required 0", gid);
    end
    @(negedge wclk);
    req_valid = '0;
    wait_idle(UPD + 10);
  endtask

`ifdef UPDATE_SCHED_STATS_EN
  task automatic one_update(input int n);
    int gid, t;
    @(negedge wclk);
    set_req(0, 1'b1, key_of(n), 2'(n));
    wait_accept(5, gid, t);
    @(negedge wclk);
    req_valid = '0;
    wait_idle(UPD + 10);
  endtask

  task automatic test_stats();
    pulse_reset();
    #1;
    tests_run++;
    if (upd_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL stats_reset: upd_count=%0d, required 0", upd_count);
    end
    run_abort();
    for (int n = 0; n < 3; n++) one_update(40 + n);
    tests_run++;
    if (upd_count !== 16'd3) begin
      tests_failed++;
      $display("FAIL stats_count: upd_count=%0d, required 3", upd_count);
    end
    @(negedge wclk);
    force dut.upd_count_q = 16'hFFFF;
    @(negedge wclk);
    release dut.upd_count_q;
    one_update(50);
    tests_run++;
    if (upd_count !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL stats_saturate: upd_count=%h, required ffff", upd_count);
    end
  endtask
`endif

  initial begin
    reset     = 1'b0;
    req_valid = '0;
    req_key   = '0;
    req_slice = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_late_request();
    test_abort();
`ifdef UPDATE_SCHED_STATS_EN
    test_stats();
`endif
    @(negedge wclk);
    #3;
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_drain: %0d updates never completed, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
